instr_sequencer: RTL and testbench

- Fetch/issue front end that feeds the 9-bit datapath control unit.
- Reads instructions from a synchronous-read program ROM and holds each one on IR.
- Asserts run and owns the 2-bit step counter that the control unit decodes.
- Consumes the control unit's clear/done handshake to retire each instruction, then fetches the next, until a HALT encoding or an error.

---
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer.sv | 132 +++++++++++++
 tb/tb_instr_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Program-ROM bus plus control-unit handshake for instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [8:0]        mem_data;
    logic [8:0]        IR;
    logic              run;
    logic [1:0]        counter;
    logic              clear;
    logic              done;

    modport master (
        output mem_rd, mem_addr, IR, run, counter,
        input  mem_data, clear, done
    );

    modport slave (
        input  mem_rd, mem_addr, IR, run, counter,
        output mem_data, clear, done
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/issue front end: ROM fetch, IR hold, step counter,
//               clear/done retire, watchdog. Optional single-step mode via
//               macro INSTR_SEQ_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             start,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    input  wire logic             step,
`endif
    instr_sequencer_if.master     bus,
    output logic                  halted,
    output logic                  err,
    output logic [CNT_W-1:0]      instr_count
);

    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_HALTED
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    assign bus.mem_addr = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            bus.IR      <= '0;
            bus.counter <= '0;
            bus.run     <= 1'b0;
            bus.mem_rd  <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc         <= '0;
                        bus.mem_rd <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    bus.mem_rd <= 1'b0;
                    state      <= S_LOAD;
                end
                S_LOAD: begin
                    bus.IR      <= bus.mem_data;
                    pc          <= pc + 1'b1;
                    bus.counter <= '0;
                    if (bus.mem_data[8:6] == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALTED;
                    end else begin
                        bus.run <= 1'b1;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // done outranks both clear and the watchdog
                    if (bus.done) begin
                        if (instr_count != '1) begin
                            instr_count <= instr_count + 1'b1;
                        end
                        bus.counter <= '0;
                        bus.run     <= 1'b0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
                        state       <= S_PAUSE;
`else
                        bus.mem_rd  <= 1'b1;
                        state       <= S_FETCH;
`endif
                    end else if (bus.counter == 2'd3) begin
                        err         <= 1'b1;
                        halted      <= 1'b1;
                        bus.run     <= 1'b0;
                        bus.counter <= '0;
                        state       <= S_HALTED;
                    end else if (bus.clear) begin
                        bus.counter <= '0;
                    end else begin
                        bus.counter <= bus.counter + 1'b1;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        pc         <= '0;
                        err        <= 1'b0;
                        halted     <= 1'b0;
                        bus.mem_rd <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
`ifdef INSTR_SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (start) begin
                        pc         <= '0;
                        bus.mem_rd <= 1'b1;
                        state      <= S_FETCH;
                    end else if (step) begin
                        bus.mem_rd <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench: directed programs plus random programs
//               against a program-walking reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic        start_b = 1'b0;
    logic        step    = 1'b0;
    logic        step_b  = 1'b0;
    logic        halted, err, halted_b, err_b;
    logic [15:0] instr_count;
    logic [2:0]  count_b;

    logic [8:0]  rom_a [32];
    logic [8:0]  rom_b [4];
    int          kpol  [32];
    int          pause_cyc = 2;
    int          exp_cnt   = 0;
    int          plen;
    int          checks    = 0;
    int          errors    = 0;

    instr_sequencer_if #(.ADDR_W(5)) bus_a ();
    instr_sequencer_if #(.ADDR_W(2)) bus_b ();

    instr_sequencer #(.ADDR_W(5), .CNT_W(16)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .bus         (bus_a),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count)
    );

    instr_sequencer #(.ADDR_W(2), .CNT_W(3)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .start       (start_b),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        .step        (step_b),
`endif
        .bus         (bus_b),
        .halted      (halted_b),
        .err         (err_b),
        .instr_count (count_b)
    );

    always #5 clock = ~clock;

    // synchronous-read program ROMs
    always @(posedge clock) begin
        if (bus_a.mem_rd) bus_a.mem_data <= rom_a[bus_a.mem_addr];
        if (bus_b.mem_rd) bus_b.mem_data <= rom_b[bus_b.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic noise();
        bus_a.done  = $urandom_range(1) == 1;
        bus_a.clear = $urandom_range(1) == 1;
        start       = $urandom_range(3) == 0;
        step        = $urandom_range(3) == 0;
    endtask

    task automatic quiet();
        bus_a.done  = 1'b0;
        bus_a.clear = 1'b0;
        start       = 1'b0;
        step        = 1'b0;
    endtask

    // Walks rom_a from address 0; kpol[a] is the counter value at which the
    // control unit raises done for the instruction at a (4 = never).
    task automatic run_prog();
        int         pc    = 0;
        int         c;
        int         k;
        int         nclr;
        bit         fin   = 1'b0;
        bit         first = 1'b1;
        bit         d;
        bit         cl;
        logic [8:0] ins;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (!fin) begin
            chk("fetch_rd", bus_a.mem_rd, 1);
            chk("fetch_addr", bus_a.mem_addr, pc);
            if (first) begin
                chk("restart_err", err, 0);
                chk("restart_halted", halted, 0);
                first = 1'b0;
            end
            noise();
            @(negedge clock);
            chk("load_rd", bus_a.mem_rd, 0);
            chk("load_run", bus_a.run, 0);
            noise();
            @(negedge clock);
            quiet();
            ins = rom_a[pc];
            k   = kpol[pc];
            pc  = (pc + 1) % 32;
            chk("ir", bus_a.IR, ins);
            if (ins[8:6] == 3'o7) begin
                chk("halt_halted", halted, 1);
                chk("halt_run", bus_a.run, 0);
                chk("halt_count", instr_count, exp_cnt);
                fin = 1'b1;
            end else begin
                c    = 0;
                nclr = 0;
                forever begin
                    chk("exec_run", bus_a.run, 1);
                    chk("exec_counter", bus_a.counter, c);
                    chk("exec_ir", bus_a.IR, ins);
                    d  = (c == k);
                    cl = d ? ($urandom_range(1) == 1)
                           : (c < 3 && nclr < 2 && $urandom_range(3) == 0);
                    bus_a.done  = d;
                    bus_a.clear = cl;
                    start       = $urandom_range(7) == 0;
                    step        = $urandom_range(3) == 0;
                    @(negedge clock);
                    quiet();
                    if (d) begin
                        exp_cnt++;
                        chk("retire_run", bus_a.run, 0);
                        chk("retire_count", instr_count, exp_cnt);
                        break;
                    end
                    if (c == 3) begin
                        chk("wdog_err", err, 1);
                        chk("wdog_halted", halted, 1);
                        chk("wdog_run", bus_a.run, 0);
                        chk("wdog_count", instr_count, exp_cnt);
                        fin = 1'b1;
                        break;
                    end
                    if (cl) nclr++;
                    c = cl ? 0 : c + 1;
                end
`ifdef INSTR_SEQ_SINGLE_STEP_EN
                if (!fin) begin
                    repeat (pause_cyc) begin
                        chk("pause_rd", bus_a.mem_rd, 0);
                        chk("pause_run", bus_a.run, 0);
                        chk("pause_addr", bus_a.mem_addr, pc);
                        @(negedge clock);
                    end
                    step = 1'b1;
                    @(negedge clock);
                    step = 1'b0;
                end
`endif
            end
        end
    endtask

    initial begin
        bus_a.done  = 1'b0;
        bus_a.clear = 1'b0;
        bus_b.done  = 1'b0;
        bus_b.clear = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rom_a[i] = 9'o700;
            kpol[i]  = 0;
        end
        for (int i = 0; i < 4; i++) rom_b[i] = 9'o000;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_ir", bus_a.IR, 0);
        chk("rst_run", bus_a.run, 0);
        chk("rst_rd", bus_a.mem_rd, 0);
        chk("rst_addr", bus_a.mem_addr, 0);
        chk("rst_counter", bus_a.counter, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_count", instr_count, 0);
        reset = 1'b0;
        @(negedge clock);

        // reset abandons an add at counter 2
        rom_a[0] = 9'o201;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid_run", bus_a.run, 1);
        repeat (2) @(negedge clock);
        chk("mid_counter", bus_a.counter, 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_run", bus_a.run, 0);
        chk("mid_rst_ir", bus_a.IR, 0);
        chk("mid_rst_count", instr_count, 0);
        chk("mid_rst_rd", bus_a.mem_rd, 0);
        chk("mid_rst_addr", bus_a.mem_addr, 0);
        exp_cnt = 0;
        @(negedge clock);

        // mv then HALT, done at counter 1
        rom_a[0] = 9'o101; kpol[0] = 1;
        rom_a[1] = 9'o700;
        pause_cyc = 10;
        run_prog();
        pause_cyc = 2;

        // add, sub, HALT with done at counter 3
        rom_a[0] = 9'o201; kpol[0] = 3;
        rom_a[1] = 9'o312; kpol[1] = 3;
        rom_a[2] = 9'o700;
        run_prog();

        // watchdog, then restart re-executes ROM[0]
        rom_a[0] = 9'o201; kpol[0] = 4;
        run_prog();
        kpol[0]  = 2;
        rom_a[1] = 9'o700;
        run_prog();

        // random programs
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 32; i++) begin
                rom_a[i] = 9'o700;
                kpol[i]  = 0;
            end
            plen = $urandom_range(1, 8);
            for (int i = 0; i < plen; i++) begin
                rom_a[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
                kpol[i]  = (rom_a[i][8:6] == 3'o0) ? 0 :
                           (($urandom_range(9) == 0) ? 4 : $urandom_range(3));
            end
            pause_cyc = $urandom_range(1, 3);
            run_prog();
        end

        // ADDR_W=2 nop loop: PC wrap and saturating 3-bit count
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        for (int n = 0; n < 9; n++) begin
            chk("b_fetch_rd", bus_b.mem_rd, 1);
            chk("b_fetch_addr", bus_b.mem_addr, n % 4);
            repeat (2) @(negedge clock);
            chk("b_run", bus_b.run, 1);
            chk("b_counter", bus_b.counter, 0);
            bus_b.done = 1'b1;
            @(negedge clock);
            bus_b.done = 1'b0;
            chk("b_count", count_b, (n + 1 > 7) ? 7 : n + 1);
`ifdef INSTR_SEQ_SINGLE_STEP_EN
            step_b = 1'b1;
            @(negedge clock);
            step_b = 1'b0;
`endif
        end
        chk("b_err", err_b, 0);
        chk("b_halted", halted_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
